// File: rtl/bcd_convert_scheduler.sv
// Round-robin shared binary-to-BCD converter for two requesters.
// Ports: clk, reset, req[1:0], data0/data1 in; ack, done, busy, D3..D0, neg, ovf, src out.
module bcd_convert_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  ack,
  output logic [1:0]  done,
  output logic        busy,
  output logic [3:0]  D3,
  output logic [3:0]  D2,
  output logic [3:0]  D1,
  output logic [3:0]  D0,
  output logic        neg,
  output logic        ovf,
  output logic        src
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        sel_q, sel_d;
  logic [15:0] data_q, data_d;
  logic [13:0] rem_q, rem_d;
  logic [15:0] sh_q, sh_d;
  logic        sneg_q, sneg_d;
  logic        sovf_q, sovf_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic [15:0] dig_q, dig_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;
  logic        src_q, src_d;

  logic        gnt;
  logic [16:0] mag;

  // Both requesting: the one not granted last wins.
  assign gnt = (req == 2'b11) ? ~ptr_q : req[1];

  // 17-bit magnitude so that 0x8000 yields 32768.
  assign mag = data_q[15] ? (17'd0 - {1'b1, data_q})
                          : {1'b0, data_q};

  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    sneg_d  = sneg_q;
    sovf_d  = sovf_q;
    ack_d   = 2'b00;
    done_d  = 2'b00;
    // busy is registered so it also covers the done cycle.
    busy_d  = (state_q != IDLE);
    dig_d   = dig_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    src_d   = src_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          ack_d[gnt] = 1'b1;
          sel_d      = gnt;
          ptr_d      = gnt;
          data_d     = gnt ? data1 : data0;
          busy_d     = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        sneg_d = data_q[15];
        sovf_d = (mag > 17'd9999);
        sh_d   = '0;
        rem_d  = mag[13:0];
        if ((mag > 17'd9999) || (mag == 17'd0)) begin
          state_d = DONE;
        end else begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        sh_d  = bcd_inc(sh_q);
        rem_d = rem_q - 14'd1;
        if (rem_q == 14'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        dig_d        = sovf_q ? 16'd0 : sh_q;
        neg_d        = sneg_q;
        ovf_d        = sovf_q;
        src_d        = sel_q;
        done_d[sel_q] = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      sel_q   <= 1'b0;
      data_q  <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      sneg_q  <= 1'b0;
      sovf_q  <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      dig_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      sneg_q  <= sneg_d;
      sovf_q  <= sovf_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dig_q   <= dig_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      src_q   <= src_d;
    end
  end

  assign ack  = ack_q;
  assign done = done_q;
  assign busy = busy_q;
  assign D3   = dig_q[15:12];
  assign D2   = dig_q[11:8];
  assign D1   = dig_q[7:4];
  assign D0   = dig_q[3:0];
  assign neg  = neg_q;
  assign ovf  = ovf_q;
  assign src  = src_q;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Scoreboard bench for bcd_convert_scheduler.
// Driver predicts grants and results; monitor pops on done.
module tb_bcd_convert_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] data0 = '0;
  logic [15:0] data1 = '0;
  logic [1:0]  ack, done;
  logic        busy;
  logic [3:0]  D3, D2, D1, D0;
  logic        neg, ovf, src;

  bcd_convert_scheduler dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1),
    .ack(ack), .done(done), .busy(busy),
    .D3(D3), .D2(D2), .D1(D1), .D0(D0),
    .neg(neg), .ovf(ovf), .src(src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int g;
    int res;
    int t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ptr = 1;
  int   last = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Result word: digits as a decimal number, plus flags.
  function automatic int pack(input int dec, input int n, input int o, input int s);
    return dec * 8 + n * 4 + o * 2 + s;
  endfunction

  function automatic int out_word();
    int dec;
    dec = int'(D3) * 1000 + int'(D2) * 100 + int'(D1) * 10 + int'(D0);
    return pack(dec, int'(neg), int'(ovf), int'(src));
  endfunction

  function automatic exp_t model(input logic [15:0] v, input int g, input int now);
    exp_t e;
    int   sv, m, o;
    sv = int'($signed(v));
    m  = (sv < 0) ? -sv : sv;
    o  = (m > 9999) ? 1 : 0;
    e.g   = g;
    e.res = pack(o ? 0 : m, (sv < 0) ? 1 : 0, o, g);
    e.t   = now + (o ? 2 : m + 2);
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (!reset) begin
      chk("ack_done_overlap", int'(ack & done), 0);
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("spurious_done", int'(done), 0);
        end else begin
          e = sb.pop_front();
          chk("done_vec", int'(done), 1 << e.g);
          chk("done_cycle", cyc, e.t);
          chk("result", out_word(), e.res);
          last = e.res;
        end
      end else begin
        chk("hold_outputs", out_word(), last);
      end
    end
  end

  task automatic wait_grant(output int g);
    int n;
    int p;
    n = 0;
    g = -1;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < 12000);
    if (ack == 2'b00) begin
      chk("grant_timeout", 0, 1);
      req = 2'b00;
      return;
    end
    p   = (req == 2'b11) ? (1 - ptr) : int'(req[1]);
    ptr = p;
    chk("ack_vec", int'(ack), 1 << p);
    chk("busy_at_ack", int'(busy), 1);
    chk("grant_while_busy", sb.size(), 0);
    sb.push_back(model(p ? data1 : data0, p, cyc));
    g = p;
  endtask

  task automatic single(input int r, input logic [15:0] v);
    int g;
    @(negedge clk);
    if (r == 0) data0 = v;
    else        data1 = v;
    req[r] = 1'b1;
    wait_grant(g);
    req[r] = 1'b0;
  endtask

  function automatic logic [15:0] rnd_small();
    int v;
    v = $urandom_range(0, 400);
    if ($urandom_range(0, 1) == 1) v = -v;
    return 16'(v);
  endfunction

  initial begin
    int g;
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", out_word(), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack_done", int'({ack, done}), 0);

    single(0, 16'd1234);
    single(1, 16'hFFD3);
    single(1, 16'd0);
    single(0, 16'd10000);
    single(0, 16'h8000);
    single(0, 16'd9999);

    // Fresh reset so the pointer starts at 1 for the both-request test.
    @(negedge clk);
    while (sb.size() != 0) @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ptr   = 1;
    last  = 0;
    @(negedge clk);
    reset = 1'b0;
    data0 = rnd_small();
    data1 = rnd_small();
    req   = 2'b11;
    wait_grant(g);
    req[g] = 1'b0;
    wait_grant(g);
    req[g] = 1'b0;
    @(negedge clk);
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      if (g < 0) break;
      req[g] = 1'b0;
      if (g == 0) data0 = rnd_small();
      else        data1 = rnd_small();
      @(negedge clk);
      req[g] = 1'b1;
    end
    n = 0;
    while (req != 2'b00 && n < 4) begin
      wait_grant(g);
      if (g >= 0) req[g] = 1'b0;
      n++;
    end

    // Single requester held high across grants.
    @(negedge clk);
    data0 = rnd_small();
    req   = 2'b01;
    for (int k = 0; k < 3; k++) begin
      wait_grant(g);
      data0 = rnd_small();
    end
    req = 2'b00;

    // Data change and competing request during COUNT.
    single(0, 16'd300);
    repeat (50) @(negedge clk);
    data0  = 16'hBEEF;
    data1  = 16'd77;
    req[1] = 1'b1;
    wait_grant(g);
    req[1] = 1'b0;

    for (int k = 0; k < 10; k++) begin
      logic [15:0] v;
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom);
        1:       v = 16'($urandom_range(9990, 10010));
        default: v = rnd_small();
      endcase
      single(int'($urandom_range(0, 1)), v);
    end

    // Reset in the middle of a 500-count conversion.
    single(0, 16'd500);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    ptr  = 1;
    last = 0;
    @(negedge clk);
    chk("midrst_outputs", out_word(), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (600) @(negedge clk);
    chk("post_rst_digits", out_word(), 0);

    single(1, 16'd42);

    n = 0;
    while (sb.size() != 0 && n < 15000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    chk("final_busy", int'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_convert_scheduler.md
# bcd_convert_scheduler

Shares one iterative binary-to-BCD conversion engine between two requesters in the calculator SoC: operand entry (port 0) and ALU result (port 1). It arbitrates round-robin, accepts a signed 16-bit value through a level request / ack pulse handshake, and converts it by counting BCD digits up to the magnitude. It then presents the four digits, sign and overflow to the seven-segment display path. Output digits change only at completion, so the display never shows intermediate count values.

## Interface
- No parameters; widths are fixed (16-bit two's-complement input, 4 BCD digits, 2 requesters).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- req  in  2  level request per requester; bit i = requester i
- data0  in  16  requester 0 value, two's complement
- data1  in  16  requester 1 value, two's complement
- ack  out  2  one-cycle pulse: request i granted, data sampled
- done  out  2  one-cycle pulse: conversion for requester i complete, outputs valid
- busy  out  1  high in any state other than IDLE
- D3, D2, D1, D0  out  4 each  BCD thousands/hundreds/tens/ones of last completed conversion
- neg  out  1  sign of last completed conversion
- ovf  out  1  last completed magnitude exceeded 9999
- src  out  1  requester index of last completed conversion

## Operation
- States: IDLE, LOAD, COUNT, DONE.
- IDLE: if any req bit is set, grant one requester. Capture its data, pulse ack[i], record i, go to LOAD.
- Arbitration: a last-grant pointer is cleared to 1 by reset, so requester 0 wins first.
  - Both requesting: grant the requester that is not the pointer.
  - Only one requesting: grant it regardless of the pointer.
  - The pointer updates on every grant.
- Requests are level-sensitive. A requester holds data stable until its ack and drops req in the ack cycle. A req still high back in IDLE is a new request and is re-granted per arbitration.
- LOAD:
  - neg = data[15].
  - Magnitude M = neg ? -data : data, as a 17-bit value, so 0x8000 gives 32768.
  - ovf = (M > 9999).
  - Clear the shadow BCD digits; remaining = M.
  - Next state is DONE if ovf or M == 0, otherwise COUNT.
- COUNT: each cycle, increment the shadow BCD by one with decimal carry (ones→tens→hundreds→thousands) and decrement remaining. Go to DONE on the cycle remaining goes from 1 to 0.
- DONE:
  - Copy shadow digits to D3..D0 (all zero if ovf); update neg, ovf, src.
  - Pulse done[src]; return to IDLE.
- The shadow counter never exceeds 9999, so the thousands digit never wraps.
- req/data changes during LOAD/COUNT/DONE are ignored; no grant occurs outside IDLE.

## Timing
- Reset values: state IDLE; ack=0, done=0, busy=0; D3..D0=0; neg=0, ovf=0, src=0; pointer=1.
- Reset asserted mid-conversion aborts immediately: no done pulse, outputs return to reset values.
- Cycle timing: req sampled high at edge E0; ack[i] high for the cycle after E0; LOAD at E1; COUNT at edges E2..E(M+1); DONE at E(M+2).
- Outputs and done[i] are valid in the cycle after E(M+2). This holds for M = 0 and for ovf, where DONE is at E2.
- Conversion latency is M+2 edges from grant (max 10001). The earliest next grant is at E(M+3).
- busy is high from the cycle after E0 through the done cycle inclusive.
- ack and done are never high in the same cycle for the same requester.

## Test plan
- Reset then idle: all outputs zero and busy=0. Assert reset mid-COUNT of 500: no done pulse; D3..D0=0 after reset.
- req0 with data0=1234 (0x04D2) → ack[0] one cycle; done[0] after edge E1236; D=1,2,3,4; neg=0, ovf=0, src=0. D stays at the prior value until then.
- req1 with data1=0xFFD3 (−45) → D=0,0,4,5; neg=1, ovf=0, src=1, at E47. With data1=0 → D=0,0,0,0 at E2.
- data0=10000 → ovf=1, D=0000, done at E2. data0=0x8000 → ovf=1, neg=1. data0=9999 → D=9,9,9,9, ovf=0.
- req=2'b11 from reset, each requester drops req after its ack → requester 0 served first, then requester 1. Both re-asserted together → requester 0 again, alternating thereafter. Single requester held high → back-to-back grants.
- Change data0 and assert req1 during an active COUNT → the current result is unchanged; req1 is granted only after done.
